uart_rx_cfg: RTL

- Configurable UART receiver: the receive-side counterpart of the team's configurable transmitter, with matching framing controls.
- Recovers 8-bit LSB-first frames from the asynchronous `rxd` line.
- Framing options: optional odd parity and 1 or 2 stop bits.
- Outputs each byte with a one-cycle valid strobe plus parity and framing error flags, for the host logic behind the UART pins.

---
 rtl/uart_pkg.sv | 49 ++++
 rtl/uart_rx_sync.sv | 48 ++++
 rtl/uart_rx_cfg.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the configurable UART blocks.
//
// Contents:
//   calc_cycle / calc_half : clocks-per-bit and mid-bit offset from clock
//                            frequency (MHz) and baud rate
//   frame_cfg_t            : per-frame framing options (parity, stop bits)
//   rx_state_e             : receiver state encoding
//   odd_parity             : parity bit value that makes the frame odd
// ---------------------------------------------------------------------------
package uart_pkg;

  // Clocks per bit. Computed in 64 bits so large clock rates cannot overflow
  // the intermediate product.
  function automatic int calc_cycle(input int clk_fre_mhz, input int baud_rate);
    longint prod;
    prod = longint'(clk_fre_mhz) * 64'sd1000000;
    return int'(prod / longint'(baud_rate));
  endfunction

  // Offset from the start-bit edge to the middle of the start bit.
  function automatic int calc_half(input int cycle);
    return cycle / 2;
  endfunction

  // Framing options, captured once per frame so that the host may change the
  // control inputs at any time without corrupting a frame on the wire.
  typedef struct packed {
    logic odd;   // 1: a parity bit follows data bit 7
    logic stop;  // 1: two stop bits, 0: one stop bit
  } frame_cfg_t;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP1  = 3'd4,
    RX_STOP2  = 3'd5,
    RX_BREAK  = 3'd6
  } rx_state_e;

  // Parity bit that gives an odd number of ones across data plus parity.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// ---------------------------------------------------------------------------
// uart_rx_sync
// Two-flop synchronizer for an asynchronous line input, followed by a
// falling-edge detector on the synchronized value.
//
// Ports:
//   clk   in  : system clock
//   rst   in  : asynchronous active-high reset (line assumed at RESET_VAL)
//   din   in  : asynchronous line input
//   dout  out : synchronized line value
//   fall  out : one-cycle pulse when the synchronized line goes 1 -> 0
// ---------------------------------------------------------------------------
module uart_rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic fall
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;
  logic       prev_q;
  logic       prev_d;

  always_comb begin
    sync_d = {sync_q[0], din};
    prev_d = sync_q[1];
  end

  // Reset to the idle line level so that leaving reset never looks like an
  // edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {2{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign dout = sync_q[1];
  assign fall = prev_q & ~sync_q[1];

endmodule

// File: rtl/uart_rx_cfg.sv
// ---------------------------------------------------------------------------
// uart_rx_cfg
// Configurable UART receiver: 8 data bits LSB first, optional odd parity,
// one or two stop bits. Framing options are captured at the start edge of
// each frame.
//
// Parameters:
//   CLK_FRE    : system clock in MHz
//   BAUD_RATE  : line rate in baud (CLK_FRE*1e6/BAUD_RATE must be 4..65535)
//
// Ports:
//   clk         in     : system clock
//   rst         in     : asynchronous active-high reset
//   enable_ctrl in     : 0 = receiver enabled, 1 = disabled (checked in IDLE)
//   odd_ctrl    in     : 1 = frame carries a parity bit
//   stop_ctrl   in     : 1 = two stop bits
//   rxd         in     : serial line, idles high, asynchronous to clk
//   rx_data     out[8] : last received byte, held until the next frame
//   rx_valid    out    : one-cycle pulse when a frame completes
//   parity_err  out    : parity status of the last frame (0 if no parity)
//   frame_err   out    : a stop bit of the last frame was sampled low
//   busy        out    : receiver is not in IDLE
// ---------------------------------------------------------------------------
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_FRE   = 50,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable_ctrl,
  input  logic       odd_ctrl,
  input  logic       stop_ctrl,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int CYCLE = calc_cycle(CLK_FRE, BAUD_RATE);
  localparam int HALF  = calc_half(CYCLE);

  localparam logic [15:0] CYCLE_T = 16'(CYCLE);
  localparam logic [15:0] HALF_T  = 16'(HALF);

  // -------------------------------------------------------------------------
  // Line synchronizer
  // -------------------------------------------------------------------------
  logic rxd_s;
  logic rxd_fall;

  uart_rx_sync #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (rxd),
    .dout (rxd_s),
    .fall (rxd_fall)
  );

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  rx_state_e  state_q,      state_d;
  logic [15:0] timer_q,     timer_d;
  logic [2:0]  idx_q,       idx_d;
  logic [7:0]  shift_q,     shift_d;
  frame_cfg_t  cfg_q,       cfg_d;
  logic        perr_pend_q, perr_pend_d;  // parity result awaiting completion
  logic        ferr_pend_q, ferr_pend_d;  // first-stop result when two stops

  logic [7:0]  rx_data_q,    rx_data_d;
  logic        rx_valid_q,   rx_valid_d;
  logic        parity_err_q, parity_err_d;
  logic        frame_err_q,  frame_err_d;
  logic        busy_q,       busy_d;

  // Per-cycle helpers
  logic sample_bit;   // the bit timer reached a full-bit sample point
  logic finish;       // final stop bit sampled this cycle
  logic ferr_now;     // frame error of the frame finishing this cycle

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q + 16'd1;
    idx_d        = idx_q;
    shift_d      = shift_q;
    cfg_d        = cfg_q;
    perr_pend_d  = perr_pend_q;
    ferr_pend_d  = ferr_pend_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    finish       = 1'b0;
    ferr_now     = 1'b0;
    sample_bit   = (timer_q == CYCLE_T);

    unique case (state_q)
      RX_IDLE: begin
        timer_d = '0;
        if (rxd_fall && !enable_ctrl) begin
          cfg_d   = '{odd: odd_ctrl, stop: stop_ctrl};
          state_d = RX_START;
        end
      end

      RX_START: begin
        // Mid-start-bit check rejects short low glitches on an idle line.
        if (timer_q == HALF_T) begin
          if (!rxd_s) begin
            state_d     = RX_DATA;
            idx_d       = 3'd0;
            perr_pend_d = 1'b0;
            ferr_pend_d = 1'b0;
          end else begin
            state_d = RX_IDLE;
          end
        end
      end

      RX_DATA: begin
        if (sample_bit) begin
          shift_d[idx_q] = rxd_s;
          // Restart the timer for every bit, not only on state changes, so
          // consecutive data bits keep the CYCLE+1 sample spacing.
          timer_d = '0;
          if (idx_q == 3'd7) begin
            state_d = cfg_q.odd ? RX_PARITY : RX_STOP1;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end

      RX_PARITY: begin
        if (sample_bit) begin
          perr_pend_d = (rxd_s != odd_parity(shift_q));
          state_d     = RX_STOP1;
        end
      end

      RX_STOP1: begin
        if (sample_bit) begin
          if (cfg_q.stop) begin
            ferr_pend_d = ~rxd_s;
            state_d     = RX_STOP2;
          end else begin
            ferr_now = ~rxd_s;
            finish   = 1'b1;
          end
        end
      end

      RX_STOP2: begin
        if (sample_bit) begin
          ferr_now = ferr_pend_q | ~rxd_s;
          finish   = 1'b1;
        end
      end

      RX_BREAK: begin
        // A line held low after a bad stop bit must not be taken as a new
        // start bit; wait for it to return to idle first.
        if (rxd_s) begin
          state_d = RX_IDLE;
        end
      end

      default: begin
        state_d = RX_IDLE;
      end
    endcase

    if (finish) begin
      rx_data_d    = shift_q;
      rx_valid_d   = 1'b1;
      parity_err_d = cfg_q.odd & perr_pend_q;
      frame_err_d  = ferr_now;
      state_d      = ferr_now ? RX_BREAK : RX_IDLE;
    end

    if (state_d != state_q) begin
      timer_d = '0;
    end

    busy_d = (state_d != RX_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RX_IDLE;
      timer_q      <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      cfg_q        <= '0;
      perr_pend_q  <= 1'b0;
      ferr_pend_q  <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      cfg_q        <= cfg_d;
      perr_pend_q  <= perr_pend_d;
      ferr_pend_q  <= ferr_pend_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

endmodule
